fetch_decode: RTL and testbench

- Upstream stage of the processor datapath.
- Fetches 32-bit instruction words from instruction memory at the PC supplied by the datapath. Decodes each word into the datapath control bundle (alucode, op1, op2, imControl, flag, flag1, regenable, ramenable, pcControl, writecode).
- Issues a one-cycle exec_en strobe per instruction; the datapath uses it as its clock enable for register, RAM and PC updates.
- Also handles start/halt sequencing, fetch timeout and illegal-opcode reporting.

---
 rtl/fetch_decode_if.sv | 24 ++
 rtl/fetch_decode.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_decode.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// Instruction-memory fetch bus: the fetch unit drives address/request,
// the memory answers with a data word qualified by imem_ready.
interface fetch_decode_if #(
  parameter int IMEM_AW = 10
);
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_req;
  logic [31:0]        imem_rdata;
  logic               imem_ready;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode front end of the processor datapath.
// Fetches one instruction word per FETCH phase, registers its decode,
// and presents it for exactly one EXEC cycle with an exec_en strobe that
// the datapath uses as its clock enable. Also sequences start/halt,
// detects fetch timeouts and reports illegal opcodes.
module fetch_decode #(
  parameter int IMEM_AW       = 10,
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [31:0]          pc,
  fetch_decode_if.master       imem,
  output logic                 exec_en,
  output logic [4:0]           alucode,
  output logic [2:0]           op1,
  output logic [20:0]          op2,
  output logic                 imControl,
  output logic                 flag,
  output logic                 flag1,
  output logic                 regenable,
  output logic [1:0]           ramenable,
  output logic [2:0]           pcControl,
  output logic [1:0]           writecode,
  output logic                 halted,
  output logic                 fault,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_count
);

  localparam int TO_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);

  // Opcode landmarks of the instruction set
  localparam logic [4:0] OPC_LAST_ALU   = 5'd11;
  localparam logic [4:0] OPC_MOV        = 5'd12;
  localparam logic [4:0] OPC_STORE      = 5'd13;
  localparam logic [4:0] OPC_FIRST_BR   = 5'd14;
  localparam logic [4:0] OPC_LAST_BR    = 5'd20;
  localparam logic [4:0] OPC_NOP        = 5'd21;
  localparam logic [4:0] OPC_HALT       = 5'd31;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Operand fields of the instruction register (opcode bits live only in
  // their decoded form below)
  logic [26:0]      ir_q, ir_d;

  // Registered decode of the instruction held in the IR
  logic [4:0]       alucode_q, alucode_d;
  logic             regen_q, regen_d;
  logic [1:0]       ramen_q, ramen_d;
  logic [2:0]       pcCtl_q, pcCtl_d;
  logic [1:0]       writecode_q, writecode_d;
  logic             execOk_q, execOk_d;
  logic             illegal_q, illegal_d;
  logic             halt_q, halt_d;

  logic             fetchDone;
  logic [4:0]       opcode;
  logic             inExec;
  logic             unusedPcBits;

  assign fetchDone    = (state_q == FETCH) && imem.imem_ready;
  assign opcode       = imem.imem_rdata[31:27];
  assign unusedPcBits = ^pc[31:IMEM_AW];

  // State register and fetch timeout counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: sequencing of fetch, execute, halt and fault
  always_comb begin
    state_d   = state_q;
    timeout_d = '0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (imem.imem_ready) begin
          state_d = EXEC;
        end else if (timeout_q == TO_W'(FETCH_TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end
      EXEC: begin
        state_d = halt_q ? HALTED : FETCH;
      end
      HALTED: begin
        if (start) state_d = FETCH;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Instruction register, decode bundle and retired-instruction counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q        <= '0;
      alucode_q   <= '0;
      regen_q     <= 1'b0;
      ramen_q     <= '0;
      pcCtl_q     <= '0;
      writecode_q <= '0;
      execOk_q    <= 1'b0;
      illegal_q   <= 1'b0;
      halt_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      ir_q        <= ir_d;
      alucode_q   <= alucode_d;
      regen_q     <= regen_d;
      ramen_q     <= ramen_d;
      pcCtl_q     <= pcCtl_d;
      writecode_q <= writecode_d;
      execOk_q    <= execOk_d;
      illegal_q   <= illegal_d;
      halt_q      <= halt_d;
      count_q     <= count_d;
    end
  end

  // Decode of the incoming word, captured only on the fetch handshake
  always_comb begin
    ir_d        = ir_q;
    alucode_d   = alucode_q;
    regen_d     = regen_q;
    ramen_d     = ramen_q;
    pcCtl_d     = pcCtl_q;
    writecode_d = writecode_q;
    execOk_d    = execOk_q;
    illegal_d   = illegal_q;
    halt_d      = halt_q;
    count_d     = count_q;
    if (fetchDone) begin
      ir_d        = imem.imem_rdata[26:0];
      alucode_d   = (opcode <= OPC_LAST_ALU) ? opcode : 5'd0;
      regen_d     = (opcode <= OPC_MOV);
      ramen_d     = (opcode == OPC_STORE) ? 2'b01 : 2'b00;
      pcCtl_d     = ((opcode >= OPC_FIRST_BR) && (opcode <= OPC_LAST_BR))
                    ? 3'(opcode - OPC_STORE) : 3'd0;
      writecode_d = (opcode == OPC_MOV) ? 2'd1 : 2'd0;
      execOk_d    = (opcode <= OPC_NOP);
      illegal_d   = (opcode > OPC_NOP) && (opcode != OPC_HALT);
      halt_d      = (opcode == OPC_HALT);
      if ((opcode <= OPC_NOP) && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Output logic: strobes and enables are only live during EXEC
  always_comb begin
    inExec         = (state_q == EXEC);
    imem.imem_req  = (state_q == FETCH);
    imem.imem_addr = (state_q == FETCH) ? pc[IMEM_AW-1:0] : '0;
    exec_en        = inExec && execOk_q;
    regenable      = inExec && execOk_q && regen_q;
    ramenable      = (inExec && execOk_q) ? ramen_q : 2'b00;
    illegal        = inExec && illegal_q;
    halted         = (state_q == HALTED);
    fault          = (state_q == FAULT);
  end

  assign alucode     = alucode_q;
  assign op1         = ir_q[26:24];
  assign op2         = ir_q[23:3];
  assign imControl   = ir_q[2];
  assign flag        = ir_q[1];
  assign flag1       = ir_q[0];
  assign pcControl   = pcCtl_q;
  assign writecode   = writecode_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: the bench plays instruction memory
// and datapath, predicts each response with an opcode-level model and a
// separate monitor compares whatever the DUT presents.
module tb_fetch_decode;
  localparam int IMEM_AW = 10;
  localparam int CNT_W   = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       pc = 32'd0;
  logic              exec_en;
  logic [4:0]        alucode;
  logic [2:0]        op1;
  logic [20:0]       op2;
  logic              imControl, flag, flag1, regenable;
  logic [1:0]        ramenable;
  logic [2:0]        pcControl;
  logic [1:0]        writecode;
  logic              halted, fault, illegal;
  logic [CNT_W-1:0]  instr_count;

  fetch_decode_if #(.IMEM_AW(IMEM_AW)) imem ();

  fetch_decode #(.IMEM_AW(IMEM_AW), .CNT_W(CNT_W), .FETCH_TIMEOUT(255)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pc(pc), .imem(imem),
    .exec_en(exec_en), .alucode(alucode), .op1(op1), .op2(op2),
    .imControl(imControl), .flag(flag), .flag1(flag1), .regenable(regenable),
    .ramenable(ramenable), .pcControl(pcControl), .writecode(writecode),
    .halted(halted), .fault(fault), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        execEn;
    logic        illegal;
    logic        halted;
    logic [4:0]  alucode;
    logic [2:0]  op1;
    logic [20:0] op2;
    logic        imControl;
    logic        flag;
    logic        flag1;
    logic        regenable;
    logic [1:0]  ramenable;
    logic [2:0]  pcControl;
    logic [1:0]  writecode;
    logic [15:0] count;
  } resp_t;

  resp_t expQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;
  int    modelCount = 0;
  int    lastWait = 0;
  logic  haltedPrev = 1'b0;

  // Opcode-level model of what one instruction word should produce
  function automatic resp_t refModel(input logic [31:0] word, input int cnt);
    resp_t r;
    int    opc;
    int    newCnt;
    opc    = int'(word >> 27);
    newCnt = cnt;
    r      = '0;
    r.op1       = word[26:24];
    r.op2       = word[23:3];
    r.imControl = word[2];
    r.flag      = word[1];
    r.flag1     = word[0];
    if (opc <= 11) begin
      r.alucode = 5'(opc); r.regenable = 1'b1; r.execEn = 1'b1;
    end else if (opc == 12) begin
      r.writecode = 2'd1; r.regenable = 1'b1; r.execEn = 1'b1;
    end else if (opc == 13) begin
      r.ramenable = 2'b01; r.execEn = 1'b1;
    end else if (opc <= 20) begin
      r.pcControl = 3'(opc - 13); r.execEn = 1'b1;
    end else if (opc == 21) begin
      r.execEn = 1'b1;
    end else if (opc == 31) begin
      r.halted = 1'b1;
    end else begin
      r.illegal = 1'b1;
    end
    if (r.execEn && newCnt < 65535) newCnt++;
    r.count = 16'(newCnt);
    return r;
  endfunction

  function automatic resp_t actResp();
    resp_t a;
    a = {exec_en, illegal, halted, alucode, op1, op2, imControl, flag, flag1,
         regenable, ramenable, pcControl, writecode, instr_count};
    return a;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Play memory for one fetch: wait for the request, stall 'delay' cycles,
  // answer with 'word' and record the expected response
  task automatic applyStimulus(input logic [31:0] word, input int delay);
    int    waited;
    resp_t r;
    waited = 0;
    while (!imem.imem_req && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    lastWait = waited;
    if (!imem.imem_req) begin
      checkOutput("req_wait_timeout", 64'(imem.imem_req), 64'd1);
      return;
    end
    checkOutput("imem_addr", 64'(imem.imem_addr), 64'(pc[IMEM_AW-1:0]));
    for (int i = 0; i < delay; i++) begin
      imem.imem_ready = 1'b0;
      imem.imem_rdata = $urandom;
      @(negedge clock);
      checkOutput("req_held_no_exec", 64'({imem.imem_req, exec_en}), 64'd2);
    end
    imem.imem_rdata = word;
    imem.imem_ready = 1'b1;
    r = refModel(word, modelCount);
    modelCount = int'(r.count);
    expQ.push_back(r);
    @(negedge clock);
    imem.imem_ready = 1'b0;
    imem.imem_rdata = $urandom;
    if (r.execEn) pc = $urandom;
  endtask

  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Monitor: compare each DUT response against the oldest expectation
  always @(negedge clock) begin
    resp_t act;
    resp_t exp;
    if (reset_n && (exec_en || illegal || (halted && !haltedPrev))) begin
      act = actResp();
      if (expQ.size() == 0) begin
        checkOutput("unexpected_response", 64'(act), 64'd0);
      end else begin
        exp = expQ.pop_front();
        checkOutput("decode_response", 64'(act), 64'(exp));
      end
    end
    haltedPrev = halted;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [31:0] word;
    int          opc;
    int          reqCycles;

    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'd0;
    repeat (3) @(negedge clock);
    checkOutput("reset_bundle", 64'(actResp()), 64'd0);
    checkOutput("reset_bus", 64'({fault, imem.imem_req, imem.imem_addr}), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("idle_no_req", 64'({imem.imem_req, exec_en}), 64'd0);

    // First instruction with immediate ready
    pulseStart();
    applyStimulus(32'h0A00002C, 0);
    checkOutput("first_instr",
                64'({alucode, op1, op2, imControl, regenable, writecode, exec_en, instr_count}),
                64'({5'd1, 3'd2, 21'd5, 1'b1, 1'b1, 2'd0, 1'b1, 16'd1}));

    // Ready delayed by three cycles
    applyStimulus({5'd3, 27'($urandom)}, 3);

    // Back-to-back fetches: one exec_en every second cycle
    for (int i = 0; i < 6; i++) begin
      opc = $urandom_range(0, 21);
      applyStimulus({opc[4:0], 27'($urandom)}, 0);
      if (i > 0) checkOutput("throughput_gap", 64'(lastWait), 64'd1);
    end

    // Branch and store decode
    applyStimulus(32'hA0000000, 0);
    checkOutput("branch7", 64'({pcControl, regenable, exec_en}), 64'({3'd7, 1'b0, 1'b1}));
    applyStimulus(32'h68000000, 1);
    checkOutput("store", 64'({ramenable, regenable, exec_en}), 64'({2'b01, 1'b0, 1'b1}));

    // Illegal opcode: one-cycle pulse, no retire, same address refetched
    applyStimulus(32'hC8000000, 0);
    checkOutput("illegal_exec", 64'({illegal, exec_en, instr_count}),
                64'({1'b1, 1'b0, 16'(modelCount)}));
    @(negedge clock);
    checkOutput("illegal_pulse_end", 64'({illegal, imem.imem_req}), 64'd1);
    applyStimulus({5'd12, 27'($urandom)}, 0);

    // Randomised instruction stream, including illegal opcodes
    for (int i = 0; i < 150; i++) begin
      opc  = $urandom_range(0, 30);
      word = {opc[4:0], 27'($urandom)};
      applyStimulus(word, $urandom_range(0, 3));
    end

    // HALT, ignored ready while halted, then restart
    applyStimulus(32'hF8000000, 1);
    @(negedge clock);
    checkOutput("halted_state", 64'({halted, exec_en, imem.imem_req}), 64'd4);
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'h0800_0000;
    @(negedge clock);
    imem.imem_ready = 1'b0;
    @(negedge clock);
    checkOutput("halted_ignores_ready", 64'({halted, exec_en, imem.imem_req, instr_count}),
                64'({1'b1, 1'b0, 1'b0, 16'(modelCount)}));
    pc = $urandom;
    pulseStart();
    checkOutput("restart_fetch", 64'({halted, imem.imem_req}), 64'd1);
    applyStimulus({5'd4, 27'($urandom)}, 0);
    @(negedge clock);

    // Asynchronous reset in the middle of a fetch
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    checkOutput("mid_fetch_req", 64'(imem.imem_req), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_bundle", 64'(actResp()), 64'd0);
    checkOutput("async_reset_bus", 64'({fault, imem.imem_req, imem.imem_addr}), 64'd0);
    modelCount = 0;
    @(negedge clock);
    reset_n = 1'b1;

    // Fetch timeout: memory never answers
    pulseStart();
    reqCycles = 0;
    while (imem.imem_req && reqCycles < 400) begin
      reqCycles++;
      @(negedge clock);
    end
    checkOutput("timeout_cycles", 64'(reqCycles), 64'd255);
    checkOutput("fault_set", 64'({fault, imem.imem_req, exec_en}), 64'd4);
    pulseStart();
    @(negedge clock);
    checkOutput("fault_sticky", 64'({fault, imem.imem_req, instr_count}), 64'({1'b1, 1'b0, 16'd0}));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
